// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU front end.
// Covers the sequencer state encodings, default vectors and next-PC select codes.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_BOOT    = 2'd0,
    ST_RUN     = 2'd1,
    ST_HALTED  = 2'd2,
    ST_TRAPPED = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    SEL_SEQ  = 3'd0,
    SEL_BR   = 3'd1,
    SEL_JMP  = 3'd2,
    SEL_TRAP = 3'd3,
    SEL_HOLD = 3'd4
  } sel_t;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VECTOR  = 32'h0000_0080;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/adder4.sv
// Word-address incrementer: y = a + 4, wrapping modulo 2^32.
// Purely combinational.
module adder4 (
  input  logic [31:0] a,
  output logic [31:0] y
);

  assign y = a + 32'd4;

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner: boot/run/halt/trap sequencing and next fetch address.
// Redirects land on PC one cycle after sampling; PC_PLUS4 is combinational.
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter logic [31:0] TRAP_VECTOR  = DEF_TRAP_VECTOR,
  parameter int unsigned BOOT_CYCLES  = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        STALL,
  input  logic        BRANCH_TAKEN,
  input  logic [31:0] BRANCH_TARGET,
  input  logic        JUMP,
  input  logic [31:0] JUMP_TARGET,
  input  logic        TRAP,
  input  logic        HALT,
  input  logic        RESUME,
  output logic [31:0] PC,
  output logic [31:0] PC_PLUS4,
  output logic [31:0] EPC,
  output logic        FETCH_EN,
  output logic [1:0]  STATE,
  output logic        MISALIGNED
);

  if (RESET_VECTOR[1:0] != 2'b00 || TRAP_VECTOR[1:0] != 2'b00) begin : g_vec_check
    $error("pc_sequencer: RESET_VECTOR and TRAP_VECTOR must be 4-byte aligned");
  end
  if (BOOT_CYCLES < 1 || BOOT_CYCLES > 255) begin : g_boot_check
    $error("pc_sequencer: BOOT_CYCLES must be in 1..255");
  end

  localparam logic [7:0] BOOT_LAST = 8'(BOOT_CYCLES - 1);

  state_t      state;
  logic [7:0]  boot_cnt;
  sel_t        sel;
  logic        mis_now;
  logic [31:0] next_pc;

  adder4 u_adder4 (
    .a (PC),
    .y (PC_PLUS4)
  );

  // A misaligned redirect is turned into a trap before it can reach PC.
  always_comb begin
    sel     = SEL_HOLD;
    mis_now = 1'b0;
    case (state)
      ST_RUN: begin
        if (TRAP) begin
          sel = SEL_TRAP;
        end else if (HALT || STALL) begin
          sel = SEL_HOLD;
        end else if (JUMP) begin
          if (is_misaligned(JUMP_TARGET)) begin
            sel     = SEL_TRAP;
            mis_now = 1'b1;
          end else begin
            sel = SEL_JMP;
          end
        end else if (BRANCH_TAKEN) begin
          if (is_misaligned(BRANCH_TARGET)) begin
            sel     = SEL_TRAP;
            mis_now = 1'b1;
          end else begin
            sel = SEL_BR;
          end
        end else begin
          sel = SEL_SEQ;
        end
      end
      ST_HALTED: begin
        if (TRAP) begin
          sel = SEL_TRAP;
        end else if (RESUME) begin
          sel = SEL_SEQ;
        end
      end
      default: sel = SEL_HOLD;
    endcase
  end

  always_comb begin
    next_pc = PC;
    case (sel)
      SEL_SEQ:  next_pc = PC_PLUS4;
      SEL_BR:   next_pc = BRANCH_TARGET;
      SEL_JMP:  next_pc = JUMP_TARGET;
      SEL_TRAP: next_pc = TRAP_VECTOR;
      default:  next_pc = PC;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      PC         <= RESET_VECTOR;
      EPC        <= 32'h0;
      state      <= ST_BOOT;
      boot_cnt   <= 8'h0;
      MISALIGNED <= 1'b0;
      FETCH_EN   <= 1'b0;
    end else begin
      PC         <= next_pc;
      MISALIGNED <= mis_now;
      if (sel == SEL_TRAP) begin
        EPC <= PC;
      end
      case (state)
        ST_BOOT: begin
          boot_cnt <= boot_cnt + 8'd1;
          if (boot_cnt == BOOT_LAST) begin
            state    <= ST_RUN;
            FETCH_EN <= 1'b1;
          end
        end
        ST_RUN: begin
          if (sel == SEL_TRAP) begin
            state    <= ST_TRAPPED;
            FETCH_EN <= 1'b0;
          end else if (HALT) begin
            state    <= ST_HALTED;
            FETCH_EN <= 1'b0;
          end
        end
        ST_HALTED: begin
          if (sel == SEL_TRAP) begin
            state <= ST_TRAPPED;
          end else if (RESUME) begin
            state    <= ST_RUN;
            FETCH_EN <= 1'b1;
          end
        end
        default: begin
          // TRAPPED holds PC at the trap vector so the first RUN cycle fetches it.
          state    <= ST_RUN;
          FETCH_EN <= 1'b1;
        end
      endcase
    end
  end

  assign STATE = state;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: boot, priority, misaligned, halt, wrap, reset-in-trap.
module tb_pc_sequencer;

  logic        CLK = 1'b0;
  logic        RST;
  logic        STALL;
  logic        BRANCH_TAKEN;
  logic [31:0] BRANCH_TARGET;
  logic        JUMP;
  logic [31:0] JUMP_TARGET;
  logic        TRAP;
  logic        HALT;
  logic        RESUME;
  logic [31:0] PC;
  logic [31:0] PC_PLUS4;
  logic [31:0] EPC;
  logic        FETCH_EN;
  logic [1:0]  STATE;
  logic        MISALIGNED;

  int checks = 0;
  int passes = 0;

  pc_sequencer #(
    .RESET_VECTOR (32'h0000_0000),
    .TRAP_VECTOR  (32'h0000_0080),
    .BOOT_CYCLES  (4)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .STALL         (STALL),
    .BRANCH_TAKEN  (BRANCH_TAKEN),
    .BRANCH_TARGET (BRANCH_TARGET),
    .JUMP          (JUMP),
    .JUMP_TARGET   (JUMP_TARGET),
    .TRAP          (TRAP),
    .HALT          (HALT),
    .RESUME        (RESUME),
    .PC            (PC),
    .PC_PLUS4      (PC_PLUS4),
    .EPC           (EPC),
    .FETCH_EN      (FETCH_EN),
    .STATE         (STATE),
    .MISALIGNED    (MISALIGNED)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic chk_core(input string tag, input logic [31:0] pc, input logic [1:0] st,
                          input logic fe, input logic mis);
    chk({tag, "_pc"}, PC, pc);
    chk({tag, "_state"}, {30'd0, STATE}, {30'd0, st});
    chk({tag, "_fetch"}, {31'd0, FETCH_EN}, {31'd0, fe});
    chk({tag, "_mis"}, {31'd0, MISALIGNED}, {31'd0, mis});
  endtask

  task automatic idle_inputs();
    STALL = 0; BRANCH_TAKEN = 0; BRANCH_TARGET = 0; JUMP = 0; JUMP_TARGET = 0;
    TRAP = 0; HALT = 0; RESUME = 0;
  endtask

  initial begin
    idle_inputs();
    RST = 1;
    step();
    step();
    chk_core("reset", 32'h0, 2'd0, 1'b0, 1'b0);
    chk("reset_epc", EPC, 32'h0);
    RST = 0;

    // Boot: inputs other than RST must be ignored.
    JUMP = 1; JUMP_TARGET = 32'h0000_0500; TRAP = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_core("boot", 32'h0, 2'd0, 1'b0, 1'b0);
    end
    idle_inputs();

    step();
    chk_core("run0", 32'h0, 2'd1, 1'b1, 1'b0);
    chk("run0_plus4", PC_PLUS4, 32'h4);
    step(); chk("seq4", PC, 32'h4);
    step(); chk("seq8", PC, 32'h8);
    step(); chk("seq12", PC, 32'hC);
    step(); chk("seq16", PC, 32'h10);

    // Stall beats jump and branch.
    STALL = 1; JUMP = 1; JUMP_TARGET = 32'h200; BRANCH_TAKEN = 1; BRANCH_TARGET = 32'h300;
    step(); chk_core("stall", 32'h10, 2'd1, 1'b1, 1'b0);
    STALL = 0;
    step(); chk("jump_over_branch", PC, 32'h200);
    JUMP = 0;
    step(); chk("branch", PC, 32'h300);
    idle_inputs();

    JUMP = 1; JUMP_TARGET = 32'h40;
    step(); chk("jump40", PC, 32'h40);
    idle_inputs();
    BRANCH_TAKEN = 1; BRANCH_TARGET = 32'h102;
    step();
    chk_core("misbr", 32'h80, 2'd3, 1'b0, 1'b1);
    chk("misbr_epc", EPC, 32'h40);
    idle_inputs();
    step(); chk_core("misbr_after", 32'h80, 2'd1, 1'b1, 1'b0);
    step(); chk("misbr_seq", PC, 32'h84);

    // Trap request; held high through TRAPPED must not recapture.
    TRAP = 1; JUMP = 1; JUMP_TARGET = 32'h600;
    step();
    chk_core("trap", 32'h80, 2'd3, 1'b0, 1'b0);
    chk("trap_epc", EPC, 32'h84);
    JUMP = 0;
    step();
    chk_core("trap_exit", 32'h80, 2'd1, 1'b1, 1'b0);
    chk("trap_no_nest", EPC, 32'h84);
    TRAP = 0;

    JUMP = 1; JUMP_TARGET = 32'h33;
    step();
    chk_core("misjmp", 32'h80, 2'd3, 1'b0, 1'b1);
    chk("misjmp_epc", EPC, 32'h80);
    idle_inputs();
    step();

    JUMP = 1; JUMP_TARGET = 32'h20;
    step(); chk("jump20", PC, 32'h20);
    idle_inputs();
    HALT = 1;
    step(); chk_core("halt", 32'h20, 2'd2, 1'b0, 1'b0);
    HALT = 0; JUMP = 1; JUMP_TARGET = 32'h400; STALL = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_core("halted", 32'h20, 2'd2, 1'b0, 1'b0);
    end
    chk("halted_epc", EPC, 32'h80);
    idle_inputs();
    RESUME = 1;
    step(); chk_core("resume", 32'h24, 2'd1, 1'b1, 1'b0);
    idle_inputs();

    JUMP = 1; JUMP_TARGET = 32'hFFFF_FFFC;
    step();
    chk("wrap_pc", PC, 32'hFFFF_FFFC);
    chk("wrap_plus4", PC_PLUS4, 32'h0);
    idle_inputs();
    step();
    chk_core("wrap", 32'h0, 2'd1, 1'b1, 1'b0);
    chk("wrap_epc", EPC, 32'h80);
    step(); chk("wrap_seq", PC, 32'h4);

    TRAP = 1;
    step();
    chk_core("trap2", 32'h80, 2'd3, 1'b0, 1'b0);
    chk("trap2_epc", EPC, 32'h4);
    RST = 1; TRAP = 0;
    step();
    chk_core("rst_in_trap", 32'h0, 2'd0, 1'b0, 1'b0);
    chk("rst_in_trap_epc", EPC, 32'h0);
    RST = 0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the program counter of the single-cycle CPU and chooses the next fetch address each cycle.
- Next-address sources: sequential PC+4, taken branch, jump, or trap vector.
- Implements boot, run, halt and stall sequencing, and captures the exception PC on traps and misaligned targets.
- Sits between the control/branch-decision logic and the instruction memory address port.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset and held during BOOT.
- TRAP_VECTOR, 32'h0000_0080, PC loaded when a trap is accepted.
- BOOT_CYCLES, 4, number of cycles spent in BOOT before the first fetch (range 1..255).

Ports:
- CLK  input  1  single clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset.
- STALL  input  1  hold PC this cycle (RUN state only).
- BRANCH_TAKEN  input  1  conditional branch resolved taken.
- BRANCH_TARGET  input  32  branch destination.
- JUMP  input  1  unconditional jump.
- JUMP_TARGET  input  32  jump destination.
- TRAP  input  1  external/software trap request.
- HALT  input  1  halt instruction decoded.
- RESUME  input  1  leave HALTED.
- PC  output  32  current fetch address.
- PC_PLUS4  output  32  PC + 4, combinational, modulo 2^32.
- EPC  output  32  PC of the instruction that trapped.
- FETCH_EN  output  1  instruction memory read enable.
- STATE  output  2  BOOT=0, RUN=1, HALTED=2, TRAPPED=3.
- MISALIGNED  output  1  one-cycle pulse when a misaligned target is rejected.

Behaviour:
- Reset: when RST=1 at an edge:
  - PC=RESET_VECTOR, EPC=0, STATE=BOOT, boot counter=0.
  - MISALIGNED=0, FETCH_EN=0.
  - RST overrides every other input, in any state and mid-operation.
- BOOT:
  - PC is held and FETCH_EN=0; the counter increments each cycle.
  - When counter==BOOT_CYCLES-1, go to RUN next cycle. The first RUN cycle fetches RESET_VECTOR.
  - All other inputs are ignored.
- RUN:
  - FETCH_EN=1.
  - Next PC is chosen by strict priority, one action per cycle:
    1. TRAP: EPC<=PC, PC<=TRAP_VECTOR, STATE<=TRAPPED.
    2. HALT: PC held, STATE<=HALTED.
    3. STALL: PC held.
    4. JUMP: PC<=JUMP_TARGET.
    5. BRANCH_TAKEN: PC<=BRANCH_TARGET.
    6. Otherwise: PC<=PC_PLUS4.
- Misaligned target:
  - Applies when the selected JUMP_TARGET or BRANCH_TARGET has bits[1:0] != 0.
  - The target is rejected: EPC<=PC, PC<=TRAP_VECTOR, STATE<=TRAPPED, MISALIGNED=1 for that cycle only.
- TRAPPED:
  - Lasts one cycle with FETCH_EN=0; PC already equals TRAP_VECTOR.
  - Next cycle STATE<=RUN. TRAP is ignored in this state, so no nested capture.
- HALTED:
  - FETCH_EN=0; PC and EPC are held.
  - RESUME=1: STATE<=RUN, PC<=PC_PLUS4, so execution continues after the halt instruction.
  - TRAP=1 in HALTED takes priority over RESUME and follows the trap path (EPC<=PC).
- Wrap-around: PC=32'hFFFF_FFFC with no redirect gives next PC 32'h0000_0000; no flag is raised.
- Latency: redirects take effect on PC the cycle after the inputs are sampled; PC_PLUS4 has zero latency.
- Width: PC bits[1:0] are always 0 after reset, given a 4-aligned RESET_VECTOR and TRAP_VECTOR. Both vectors must be 4-aligned; a parameter check flags violations at elaboration.
- STATE value 3 appears only for the single TRAPPED cycle.

Decomposition:
- Shared package cpu_pkg:
  - state encodings ST_BOOT, ST_RUN, ST_HALTED, ST_TRAPPED;
  - default vector constants;
  - the next-PC select enum (SEL_SEQ, SEL_BR, SEL_JMP, SEL_TRAP, SEL_HOLD).
- Sub-module: PC_PLUS4 is produced by instantiating the existing adder4 incrementer on PC; no other sub-modules.
- The FSM and next-PC mux stay in pc_sequencer.

Test Plan:
- Reset/boot: RST for 2 cycles, then idle with BOOT_CYCLES=4 -> PC=0 and FETCH_EN=0 for 4 cycles; then RUN with PC sequence 0, 4, 8, 12.
- Priority: at PC=0x10, assert JUMP (0x200), BRANCH_TAKEN (0x300) and STALL together -> PC stays 0x10. Next cycle, with STALL low -> PC=0x200.
- Misaligned: at PC=0x40, BRANCH_TAKEN with target 0x102 -> MISALIGNED pulses 1 cycle, EPC=0x40, PC=0x80, STATE=3 for 1 cycle, then 1 with PC=0x84.
- Halt/resume: at PC=0x20, HALT -> PC held at 0x20 and FETCH_EN=0 for 5 cycles. Then RESUME -> PC=0x24, STATE=RUN.
- Wrap: force the PC to 0xFFFF_FFFC via JUMP, then idle -> next PC=0x0000_0000, no trap.
- Reset mid-trap: assert RST during the TRAPPED cycle -> next cycle PC=RESET_VECTOR, EPC=0, STATE=BOOT.
